register_file_mp: RTL and testbench

//  Parametrised successor register file for the RISC-V core: 2 combinational read ports, 2 write

---
 rtl/register_file_mp.sv | 180 ++++++++++++++++++
 tb/tb_register_file_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp
//  Purpose  : Multi-ported register file for the RISC-V core. Two
//             combinational read ports, two write ports (WB0 = ALU result,
//             WB1 = load / long-latency result), optional same-cycle write
//             bypass, optional hardwired-zero entry 0, and a per-register
//             pending scoreboard for long-latency writes. Storage has no
//             reset; after reset an INIT sweep zeroes every entry before
//             ready is raised.
//  Ports    : clk, rst (async, active high)
//             ready                    - INIT sweep complete
//             Addr_A/B -> Data_A/B     - combinational read data
//             busy_A/B                 - pending bit of the read address
//             wr0, Addr_D0, Data_D0    - write port 0
//             wr1, Addr_D1, Data_D1    - write port 1 (also clears pending)
//             issue_en, Addr_I         - mark an entry pending
//             wr_clash                 - registered same-address dual write
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [AWIDTH-1:0] Addr_A,
    input  logic [AWIDTH-1:0] Addr_B,
    output logic [DWIDTH-1:0] Data_A,
    output logic [DWIDTH-1:0] Data_B,
    output logic              busy_A,
    output logic              busy_B,
    input  logic              wr0,
    input  logic [AWIDTH-1:0] Addr_D0,
    input  logic [DWIDTH-1:0] Data_D0,
    input  logic              wr1,
    input  logic [AWIDTH-1:0] Addr_D1,
    input  logic [DWIDTH-1:0] Data_D1,
    input  logic              issue_en,
    input  logic [AWIDTH-1:0] Addr_I,
    output logic              wr_clash
);

    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_sweep;
    logic [DWIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_busy;
    logic                r_wr_clash;

    logic                w_run;
    logic                w_same_addr;
    logic                w_we0;
    logic                w_we1;
    logic                w_clash;

    // ------------------------------------------------------------------
    // Control FSM: INIT sweeps every entry once, then RUN forever.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_sweep <= r_sweep + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_sweep == AWIDTH'(DEPTH - 1)) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_run = (r_state == ST_RUN);
    assign ready = w_run;

    // ------------------------------------------------------------------
    // Write qualification. Port 1 wins a same-address collision; writes
    // to entry 0 are discarded when it is hardwired to zero.
    // ------------------------------------------------------------------
    assign w_same_addr = (Addr_D0 == Addr_D1);
    assign w_we1 = w_run && wr1 && !((ZERO_REG != 0) && (Addr_D1 == '0));
    assign w_we0 = w_run && wr0 && !((ZERO_REG != 0) && (Addr_D0 == '0))
                   && !(wr1 && w_same_addr);
    assign w_clash = w_run && wr0 && wr1 && w_same_addr;

    // Storage: no reset, zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_run) begin
                if (r_sweep == AWIDTH'(i)) r_mem[i] <= '0;
            end else if (w_we1 && (Addr_D1 == AWIDTH'(i))) begin
                r_mem[i] <= Data_D1;
            end else if (w_we0 && (Addr_D0 == AWIDTH'(i))) begin
                r_mem[i] <= Data_D0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. Issue beats a same-cycle port-1 clear because
    // the newly issued op supersedes the one that is completing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((ZERO_REG != 0) && (i == 0)) begin
                    r_busy[i] <= 1'b0;
                end else if (issue_en && (Addr_I == AWIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wr1 && (Addr_D1 == AWIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_clash <= 1'b0;
        end else begin
            r_wr_clash <= w_clash;
        end
    end

    assign wr_clash = r_wr_clash;
    assign busy_A   = w_run && r_busy[Addr_A];
    assign busy_B   = w_run && r_busy[Addr_B];

    // ------------------------------------------------------------------
    // Read ports. Outputs are forced to zero during INIT so that the
    // not-yet-swept storage never leaks out.
    // ------------------------------------------------------------------
    always_comb begin
        Data_A = '0;
        if (!w_run || ((ZERO_REG != 0) && (Addr_A == '0))) begin
            Data_A = '0;
        end else if ((BYPASS != 0) && w_we1 && (Addr_D1 == Addr_A)) begin
            Data_A = Data_D1;
        end else if ((BYPASS != 0) && w_we0 && (Addr_D0 == Addr_A)) begin
            Data_A = Data_D0;
        end else begin
            Data_A = r_mem[Addr_A];
        end
    end

    always_comb begin
        Data_B = '0;
        if (!w_run || ((ZERO_REG != 0) && (Addr_B == '0))) begin
            Data_B = '0;
        end else if ((BYPASS != 0) && w_we1 && (Addr_D1 == Addr_B)) begin
            Data_B = Data_D1;
        end else if ((BYPASS != 0) && w_we0 && (Addr_D0 == Addr_B)) begin
            Data_B = Data_D0;
        end else begin
            Data_B = r_mem[Addr_B];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_mp
//  Purpose  : Directed self-checking bench for register_file_mp. A second
//             instance with BYPASS = 0 shares all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Addr_A, Addr_B, Addr_D0, Addr_D1, Addr_I;
    logic [31:0] Data_D0, Data_D1;
    logic        wr0, wr1, issue_en;

    logic        ready, busy_A, busy_B, wr_clash;
    logic [31:0] Data_A, Data_B;
    logic        nb_ready, nb_busy_A, nb_busy_B, nb_wr_clash;
    logic [31:0] nb_Data_A, nb_Data_B;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk(clk), .rst(rst), .ready(ready),
        .Addr_A(Addr_A), .Addr_B(Addr_B), .Data_A(Data_A), .Data_B(Data_B),
        .busy_A(busy_A), .busy_B(busy_B),
        .wr0(wr0), .Addr_D0(Addr_D0), .Data_D0(Data_D0),
        .wr1(wr1), .Addr_D1(Addr_D1), .Data_D1(Data_D1),
        .issue_en(issue_en), .Addr_I(Addr_I), .wr_clash(wr_clash)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(nb_ready),
        .Addr_A(Addr_A), .Addr_B(Addr_B), .Data_A(nb_Data_A), .Data_B(nb_Data_B),
        .busy_A(nb_busy_A), .busy_B(nb_busy_B),
        .wr0(wr0), .Addr_D0(Addr_D0), .Data_D0(Data_D0),
        .wr1(wr1), .Addr_D1(Addr_D1), .Data_D1(Data_D1),
        .issue_en(issue_en), .Addr_I(Addr_I), .wr_clash(nb_wr_clash)
    );

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0 = 1'b0; wr1 = 1'b0; issue_en = 1'b0;
        Addr_D0 = '0; Addr_D1 = '0; Addr_I = '0;
        Data_D0 = '0; Data_D1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        Addr_A = 5'd9; Addr_B = 5'd3;
        step(); step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (busy_A !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_A); end
        n_checks++; if (wr_clash !== 1'b0) begin n_fail++; $display("FAIL reset_clash: got %b want 0", wr_clash); end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_checks++;
            if (ready !== (k == 32)) begin n_fail++; $display("FAIL init_ready cycle %0d: got %b want %b", k, ready, (k == 32)); end
            n_checks++;
            if (nb_ready !== (k == 32)) begin n_fail++; $display("FAIL init_ready_nb cycle %0d: got %b want %b", k, nb_ready, (k == 32)); end
        end
        for (int i = 0; i < 32; i++) begin
            Addr_A = 5'(i); Addr_B = 5'(31 - i);
            #1;
            n_checks++; if (Data_A !== 32'h0) begin n_fail++; $display("FAIL init_read_A[%0d]: got %h want 0", i, Data_A); end
            n_checks++; if (Data_B !== 32'h0) begin n_fail++; $display("FAIL init_read_B[%0d]: got %h want 0", 31 - i, Data_B); end
            n_checks++; if (nb_Data_A !== 32'h0) begin n_fail++; $display("FAIL init_read_nb[%0d]: got %h want 0", i, nb_Data_A); end
        end
    endtask

    task automatic test_bypass();
        wr0 = 1'b1; Addr_D0 = 5'd5; Data_D0 = 32'hDEADBEEF; Addr_A = 5'd5; Addr_B = 5'd5;
        #1;
        n_checks++; if (Data_A !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want deadbeef", Data_A); end
        n_checks++; if (nb_Data_A !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h want 0", nb_Data_A); end
        step();
        idle_inputs();
        #1;
        n_checks++; if (Data_A !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_next_cycle: got %h want deadbeef", Data_A); end
        n_checks++; if (Data_B !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_next_cycle_B: got %h want deadbeef", Data_B); end
        n_checks++; if (nb_Data_A !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle: got %h want deadbeef", nb_Data_A); end
    endtask

    task automatic test_clash();
        wr0 = 1'b1; Addr_D0 = 5'd7; Data_D0 = 32'h11;
        wr1 = 1'b1; Addr_D1 = 5'd7; Data_D1 = 32'h22;
        Addr_A = 5'd7;
        #1;
        n_checks++; if (Data_A !== 32'h22) begin n_fail++; $display("FAIL clash_bypass: got %h want 22", Data_A); end
        n_checks++; if (wr_clash !== 1'b0) begin n_fail++; $display("FAIL clash_early: got %b want 0", wr_clash); end
        step();
        idle_inputs();
        #1;
        n_checks++; if (Data_A !== 32'h22) begin n_fail++; $display("FAIL clash_data: got %h want 22", Data_A); end
        n_checks++; if (nb_Data_A !== 32'h22) begin n_fail++; $display("FAIL clash_data_nb: got %h want 22", nb_Data_A); end
        n_checks++; if (wr_clash !== 1'b1) begin n_fail++; $display("FAIL clash_flag: got %b want 1", wr_clash); end
        step();
        n_checks++; if (wr_clash !== 1'b0) begin n_fail++; $display("FAIL clash_flag_clear: got %b want 0", wr_clash); end
        // Different addresses on both ports: both land, no clash.
        wr0 = 1'b1; Addr_D0 = 5'd12; Data_D0 = 32'hA5A5_0012;
        wr1 = 1'b1; Addr_D1 = 5'd13; Data_D1 = 32'h5A5A_0013;
        step();
        idle_inputs();
        Addr_A = 5'd12; Addr_B = 5'd13;
        #1;
        n_checks++; if (Data_A !== 32'hA5A5_0012) begin n_fail++; $display("FAIL dual_write_A: got %h want a5a50012", Data_A); end
        n_checks++; if (Data_B !== 32'h5A5A_0013) begin n_fail++; $display("FAIL dual_write_B: got %h want 5a5a0013", Data_B); end
        n_checks++; if (wr_clash !== 1'b0) begin n_fail++; $display("FAIL dual_write_clash: got %b want 0", wr_clash); end
    endtask

    task automatic test_zero_reg();
        wr0 = 1'b1; Addr_D0 = 5'd0; Data_D0 = 32'hFFFFFFFF;
        issue_en = 1'b1; Addr_I = 5'd0;
        Addr_A = 5'd0;
        #1;
        n_checks++; if (Data_A !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h want 0", Data_A); end
        step();
        idle_inputs();
        #1;
        n_checks++; if (Data_A !== 32'h0) begin n_fail++; $display("FAIL zero_data: got %h want 0", Data_A); end
        n_checks++; if (nb_Data_A !== 32'h0) begin n_fail++; $display("FAIL zero_data_nb: got %h want 0", nb_Data_A); end
        n_checks++; if (busy_A !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy_A); end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; Addr_I = 5'd9;
        Addr_A = 5'd9; Addr_B = 5'd10;
        step();
        idle_inputs();
        #1;
        n_checks++; if (busy_A !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b want 1", busy_A); end
        n_checks++; if (busy_B !== 1'b0) begin n_fail++; $display("FAIL sb_other: got %b want 0", busy_B); end
        step(); step();
        n_checks++; if (busy_A !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got %b want 1", busy_A); end
        wr1 = 1'b1; Addr_D1 = 5'd9; Data_D1 = 32'h55;
        step();
        idle_inputs();
        #1;
        n_checks++; if (busy_A !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b want 0", busy_A); end
        n_checks++; if (Data_A !== 32'h55) begin n_fail++; $display("FAIL sb_clear_data: got %h want 55", Data_A); end
        issue_en = 1'b1; Addr_I = 5'd9;
        wr1 = 1'b1; Addr_D1 = 5'd9; Data_D1 = 32'h66;
        step();
        idle_inputs();
        #1;
        n_checks++; if (busy_A !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", busy_A); end
        n_checks++; if (Data_A !== 32'h66) begin n_fail++; $display("FAIL sb_set_wins_data: got %h want 66", Data_A); end
        // Port 0 writes data but must leave the pending bit alone.
        wr0 = 1'b1; Addr_D0 = 5'd9; Data_D0 = 32'h77;
        step();
        idle_inputs();
        #1;
        n_checks++; if (busy_A !== 1'b1) begin n_fail++; $display("FAIL sb_wr0_keeps: got %b want 1", busy_A); end
        n_checks++; if (Data_A !== 32'h77) begin n_fail++; $display("FAIL sb_wr0_data: got %h want 77", Data_A); end
    endtask

    task automatic test_rst_midrun();
        Addr_A = 5'd9; Addr_B = 5'd5;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ready: got %b want 1", ready); end
        n_checks++; if (busy_A !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b want 1", busy_A); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready); end
        n_checks++; if (busy_A !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy_A); end
        n_checks++; if (Data_B !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", Data_B); end
        step();
        rst = 1'b0;
        // Hammer all write/issue inputs throughout the sweep; all must be ignored.
        wr0 = 1'b1; Addr_D0 = 5'd3;  Data_D0 = 32'hAAAA_0003;
        wr1 = 1'b1; Addr_D1 = 5'd20; Data_D1 = 32'hBBBB_0020;
        issue_en = 1'b1; Addr_I = 5'd4;
        Addr_A = 5'd3; Addr_B = 5'd4;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k < 32) begin
                n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL resweep_ready cycle %0d: got %b want 0", k, ready); end
                n_checks++; if (Data_A !== 32'h0) begin n_fail++; $display("FAIL resweep_data cycle %0d: got %h want 0", k, Data_A); end
                n_checks++; if (busy_B !== 1'b0) begin n_fail++; $display("FAIL resweep_busy cycle %0d: got %b want 0", k, busy_B); end
            end
        end
        idle_inputs();
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL resweep_done: got %b want 1", ready); end
        n_checks++; if (wr_clash !== 1'b0) begin n_fail++; $display("FAIL resweep_clash: got %b want 0", wr_clash); end
        for (int i = 0; i < 32; i++) begin
            Addr_A = 5'(i); Addr_B = 5'(i);
            #1;
            n_checks++; if (Data_A !== 32'h0) begin n_fail++; $display("FAIL resweep_read[%0d]: got %h want 0", i, Data_A); end
            n_checks++; if (busy_B !== 1'b0) begin n_fail++; $display("FAIL resweep_busy[%0d]: got %b want 0", i, busy_B); end
            n_checks++; if (nb_Data_A !== 32'h0) begin n_fail++; $display("FAIL resweep_read_nb[%0d]: got %h want 0", i, nb_Data_A); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_clash();
        test_zero_reg();
        test_scoreboard();
        test_rst_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
